instr_encoder: RTL

//  Sequential instruction encoder/loader: packs instruction fields into 32-bit words.

---
 rtl/instr_pkg.sv | 59 +++++
 rtl/instr_pack.sv | 41 ++++
 rtl/instr_encoder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/instr_pkg.sv
// Opcode map, field layout and kind decode shared by the encoder, the control
// decoder and bench models.
package instr_pkg;

  typedef enum logic [3:0] {
    KindR   = 4'd0,
    KindLw  = 4'd1,
    KindSw  = 4'd2,
    KindBeq = 4'd3,
    KindOri = 4'd4,
    KindBj1 = 4'd5,
    KindBj2 = 4'd6,
    KindBj3 = 4'd7
  } op_kind_e;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} fmt_e;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_BJ1 = 6'h1B;
  localparam logic [5:0] OP_BJ2 = 6'h3E;
  localparam logic [5:0] OP_BJ3 = 6'h2D;

  localparam int unsigned OpLsb    = 26;
  localparam int unsigned RsLsb    = 21;
  localparam int unsigned RtLsb    = 16;
  localparam int unsigned RdLsb    = 11;
  localparam int unsigned ShamtLsb = 6;
  localparam int unsigned FunctLsb = 0;
  localparam int unsigned ImmLsb   = 0;
  localparam int unsigned TgtLsb   = 0;

  typedef struct packed {
    logic       legal;
    fmt_e       fmt;
    logic [5:0] op;
  } op_info_t;

  function automatic op_info_t decode_kind(input logic [3:0] kind);
    op_info_t info;
    info = '{legal: 1'b1, fmt: FMT_R, op: OP_R};
    case (kind)
      KindR:   info = '{legal: 1'b1, fmt: FMT_R, op: OP_R};
      KindLw:  info = '{legal: 1'b1, fmt: FMT_I, op: OP_LW};
      KindSw:  info = '{legal: 1'b1, fmt: FMT_I, op: OP_SW};
      KindBeq: info = '{legal: 1'b1, fmt: FMT_I, op: OP_BEQ};
      KindOri: info = '{legal: 1'b1, fmt: FMT_I, op: OP_ORI};
      KindBj1: info = '{legal: 1'b1, fmt: FMT_J, op: OP_BJ1};
      KindBj2: info = '{legal: 1'b1, fmt: FMT_J, op: OP_BJ2};
      KindBj3: info = '{legal: 1'b1, fmt: FMT_J, op: OP_BJ3};
      default: info = '{legal: 1'b0, fmt: FMT_R, op: OP_R};
    endcase
    return info;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: instruction kind plus raw fields into a 32-bit word.
module instr_pack
  import instr_pkg::*;
(
  input  logic [3:0]  op_kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  op_info_t info;

  always_comb begin
    info  = decode_kind(op_kind);
    legal = info.legal;
    word  = '0;
    word[OpLsb +: 6] = info.op;
    case (info.fmt)
      FMT_R: begin
        word[RsLsb +: 5]    = rs;
        word[RtLsb +: 5]    = rt;
        word[RdLsb +: 5]    = rd;
        word[ShamtLsb +: 5] = shamt;
        word[FunctLsb +: 6] = funct;
      end
      FMT_I: begin
        word[RsLsb +: 5]   = rs;
        word[RtLsb +: 5]   = rt;
        word[ImmLsb +: 16] = imm;
      end
      default: word[TgtLsb +: 26] = target;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction loader: accepts field bundles over valid/ready and writes
// encoded words to consecutive instruction-memory addresses starting at BASE.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned BASE   = 0,
  parameter int unsigned LIMIT  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err_illegal
);

  localparam int unsigned       CntW     = ADDR_W + 1;
  localparam logic [CntW-1:0]   LimitCnt = CntW'(LIMIT);
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE);

  typedef enum logic [1:0] {StIdle, StWrite, StFull} state_e;

  state_e            state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              err_q, err_d;

  logic [31:0] pack_word;
  logic        pack_legal;
  logic        xfer;

  instr_pack u_pack (
    .op_kind (op_kind),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .shamt   (shamt),
    .funct   (funct),
    .imm     (imm),
    .target  (target),
    .word    (pack_word),
    .legal   (pack_legal)
  );

  // count_q already includes the write in flight, so ready drops right after the last slot
  assign in_ready = ~full_q & ~clear & ~reset & (state_q != StFull);
  assign xfer     = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    mem_we_d = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    count_d  = count_q;
    full_d   = full_q;
    err_d    = err_q;
    if (clear) begin
      state_d = StIdle;
      addr_d  = BaseAddr;
      count_d = '0;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end else if (xfer) begin
      if (pack_legal) begin
        mem_we_d = 1'b1;
        addr_d   = BaseAddr + count_q[ADDR_W-1:0];
        wdata_d  = pack_word;
        count_d  = count_q + CntW'(1);
        if (count_d == LimitCnt) begin
          full_d  = 1'b1;
          state_d = StFull;
        end else begin
          state_d = StWrite;
        end
      end else begin
        // Illegal bundle is swallowed: no write, no address slot used
        err_d   = 1'b1;
        state_d = StIdle;
      end
    end else if (state_q == StWrite) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      mem_we_q <= 1'b0;
      addr_q   <= BaseAddr;
      wdata_q  <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_we_q <= mem_we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      count_q  <= count_d;
      full_q   <= full_d;
      err_q    <= err_d;
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign count       = count_q;
  assign full        = full_q;
  assign err_illegal = err_q;

endmodule
